// File: rtl/team_02_pkg.sv
// ============================================================================
// team_02_pkg : shared types and constants for the team_02 Wishbone fetch engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

package team_02_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } fetch_state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

`default_nettype wire

// File: rtl/team_02_wb_fetch_fifo.sv
// ============================================================================
// team_02_fetch_fifo : synchronous word FIFO with flush, occupancy and head data
// Revision           : 1.0
// ============================================================================
`default_nettype none

module team_02_fetch_fifo
  import team_02_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  // Pop of an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees the slot.
  assign do_pop  = pop && (occ != '0);
  assign do_push = push && ((occ != FULL_OCC) || do_pop);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ <= occ + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);
  assign count = occ;

endmodule

`default_nettype wire

// File: rtl/team_02_wb_fetch.sv
// ============================================================================
// team_02_wb_fetch : Wishbone classic read engine feeding a valid/ready stream
// Revision         : 1.0
// ============================================================================
`default_nettype none

module team_02_wb_fetch
  import team_02_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  input  logic             rd_ready,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_stb_o,
  output logic             wbm_cyc_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      addr;
  logic [CNT_W-1:0] rem;
  logic             done_r;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ack_ok;
  logic             pop_ok;
  logic             last_beat;
  logic             start_ok;
  logic             start_zero;
  logic             done_next;

  // An ack only counts while a request is on the bus and no abort is cancelling it.
  assign ack_ok     = (state == REQ) && wbm_ack_i && !abort;
  assign pop_ok     = rd_valid && rd_ready;
  assign occ_next   = occ + OCC_W'(ack_ok) - OCC_W'(pop_ok);
  assign last_beat  = ack_ok && (rem == CNT_W'(1));
  assign start_ok   = (state == IDLE) && start && !abort && (word_count != '0);
  assign start_zero = (state == IDLE) && start && !abort && (word_count == '0);
  assign done_next  = start_zero || last_beat;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = fifo_full ? STALL : REQ;
        end
      end
      REQ: begin
        if (abort) begin
          state_next = IDLE;
        end else if (ack_ok) begin
          if (last_beat) begin
            state_next = IDLE;
          end else if (occ_next < FULL_OCC) begin
            state_next = REQ;
          end else begin
            state_next = STALL;
          end
        end
      end
      STALL: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!fifo_full) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    busy      = 1'b0;
    if (state == REQ) begin
      wbm_cyc_o = 1'b1;
      wbm_stb_o = 1'b1;
    end
    if (state != IDLE) begin
      busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      addr   <= '0;
      rem    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= done_next;
      if (abort) begin
        rem <= '0;
      end else if (start_ok) begin
        addr <= start_addr & ~32'd3;
        rem  <= word_count;
      end else if (ack_ok) begin
        addr <= addr + WORD_BYTES;
        rem  <= rem - CNT_W'(1);
      end
    end
  end

  team_02_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .nRst      (nRst),
    .push      (ack_ok),
    .push_data (wbm_dat_i),
    .pop       (rd_ready),
    .flush     (abort),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ),
    .head      (rd_data)
  );

  assign rd_valid  = !fifo_empty;
  assign done      = done_r;
  assign wbm_adr_o = addr;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = WB_SEL_ALL;
  assign wbm_we_o  = 1'b0;

endmodule

`default_nettype wire
